// File: rtl/trap_if.sv
// ID-stage event, CSR write and pipeline-control bundle between the core and trap_ctrl.
// The master side is the core (decoder, CSR file, fetch); the slave side is trap_ctrl.
interface trap_if #(
    parameter int unsigned XLEN = 32
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic            illegal_instr;
    logic            mret_detected;
    logic            ext_irq;
    logic            mtvec_we;
    logic [XLEN-1:0] mtvec_wdata;
    logic            mstatus_we;
    logic [XLEN-1:0] mstatus_wdata;

    logic            flush_if_id;
    logic            flush_id_ex;
    logic            stall_fetch;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            trap_busy;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] mtvec;
    logic            mie;
    logic            mpie;

    modport master (
        output id_valid, id_pc, id_instr, illegal_instr, mret_detected, ext_irq,
        output mtvec_we, mtvec_wdata, mstatus_we, mstatus_wdata,
        input  flush_if_id, flush_id_ex, stall_fetch, pc_redirect, pc_target, trap_busy,
        input  mepc, mcause, mtval, mtvec, mie, mpie
    );

    modport slave (
        input  id_valid, id_pc, id_instr, illegal_instr, mret_detected, ext_irq,
        input  mtvec_we, mtvec_wdata, mstatus_we, mstatus_wdata,
        output flush_if_id, flush_id_ex, stall_fetch, pc_redirect, pc_target, trap_busy,
        output mepc, mcause, mtval, mtvec, mie, mpie
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: accepts illegal-instruction, interrupt and MRET events
// from ID, flushes the front of the pipe for FLUSH_CYCLES, then issues a single PC redirect.
module trap_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    trap_if.slave  bus
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_EXT_IRQ = {1'b1, (XLEN-1)'(11)};

    logic [1:0]      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            kind_ret, kind_ret_nxt;

    logic [XLEN-1:0] mepc_q, mepc_nxt;
    logic [XLEN-1:0] mcause_q, mcause_nxt;
    logic [XLEN-1:0] mtval_q, mtval_nxt;
    logic [XLEN-1:0] mtvec_q, mtvec_nxt;
    logic            mie_q, mie_nxt;
    logic            mpie_q, mpie_nxt;

    logic            flush_q, flush_nxt;
    logic            stall_q, stall_nxt;
    logic            redirect_q, redirect_nxt;
    logic [XLEN-1:0] target_q, target_nxt;
    logic            busy_q, busy_nxt;

    logic            unused_wdata_bits;
    assign unused_wdata_bits = ^{bus.mtvec_wdata[1:0], bus.mstatus_wdata};

    // State, CSR and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            kind_ret   <= 1'b0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mtvec_q    <= TRAP_VECTOR;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            kind_ret   <= kind_ret_nxt;
            mepc_q     <= mepc_nxt;
            mcause_q   <= mcause_nxt;
            mtval_q    <= mtval_nxt;
            mtvec_q    <= mtvec_nxt;
            mie_q      <= mie_nxt;
            mpie_q     <= mpie_nxt;
            flush_q    <= flush_nxt;
            stall_q    <= stall_nxt;
            redirect_q <= redirect_nxt;
            target_q   <= target_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Next state, CSR updates and next-cycle control outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        kind_ret_nxt = kind_ret;
        mepc_nxt     = mepc_q;
        mcause_nxt   = mcause_q;
        mtval_nxt    = mtval_q;
        mtvec_nxt    = mtvec_q;
        mie_nxt      = mie_q;
        mpie_nxt     = mpie_q;

        if (bus.mtvec_we) begin
            mtvec_nxt = {bus.mtvec_wdata[XLEN-1:2], 2'b00};
        end
        // Software mstatus write; overridden below by an event accepted in the same cycle
        if (bus.mstatus_we) begin
            mie_nxt  = bus.mstatus_wdata[3];
            mpie_nxt = bus.mstatus_wdata[7];
        end

        case (state)
            IDLE: begin
                if (bus.id_valid) begin
                    if (bus.illegal_instr) begin
                        mepc_nxt     = bus.id_pc;
                        mcause_nxt   = CAUSE_ILLEGAL;
                        mtval_nxt    = XLEN'(bus.id_instr);
                        mpie_nxt     = mie_q;
                        mie_nxt      = 1'b0;
                        kind_ret_nxt = 1'b0;
                        cnt_nxt      = CW'(FLUSH_CYCLES);
                        state_nxt    = FLUSH;
                    end else if (bus.ext_irq && mie_q) begin
                        mepc_nxt     = bus.id_pc;
                        mcause_nxt   = CAUSE_EXT_IRQ;
                        mtval_nxt    = '0;
                        mpie_nxt     = mie_q;
                        mie_nxt      = 1'b0;
                        kind_ret_nxt = 1'b0;
                        cnt_nxt      = CW'(FLUSH_CYCLES);
                        state_nxt    = FLUSH;
                    end else if (bus.mret_detected) begin
                        mie_nxt      = mpie_q;
                        mpie_nxt     = 1'b1;
                        kind_ret_nxt = 1'b1;
                        cnt_nxt      = CW'(FLUSH_CYCLES);
                        state_nxt    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The <= guard keeps a corrupted zero count from wedging the FSM
                if (cnt <= CW'(1)) begin
                    state_nxt = REDIRECT;
                end
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            REDIRECT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered from next state so they line up with the state they decode
        flush_nxt    = (state_nxt != IDLE);
        stall_nxt    = (state_nxt == FLUSH);
        redirect_nxt = (state_nxt == REDIRECT);
        busy_nxt     = (state_nxt != IDLE);
        target_nxt   = '0;
        if (state_nxt == REDIRECT) begin
            target_nxt = kind_ret_nxt ? mepc_nxt : mtvec_nxt;
        end
    end

    assign bus.flush_if_id = flush_q;
    assign bus.flush_id_ex = flush_q;
    assign bus.stall_fetch = stall_q;
    assign bus.pc_redirect = redirect_q;
    assign bus.pc_target   = target_q;
    assign bus.trap_busy   = busy_q;
    assign bus.mepc        = mepc_q;
    assign bus.mcause      = mcause_q;
    assign bus.mtval       = mtval_q;
    assign bus.mtvec       = mtvec_q;
    assign bus.mie         = mie_q;
    assign bus.mpie        = mpie_q;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap and return sequencer for the 5-stage RISC-V core. It consumes the decoder's `ILLEGAL_INSTR` and `MRET_DETECTED` flags plus an external interrupt line, and sequences each event as flush, then PC redirect. It owns the `mepc`, `mcause`, `mtval`, `mtvec` and `mstatus.MIE/MPIE` state. It sits beside the ID stage and drives the IF/ID and ID/EX flush and fetch-stall controls.

## Interface
- `XLEN`, 32, datapath and CSR width.
- `TRAP_VECTOR`, 32'h0000_0100, reset value of `mtvec`.
- `FLUSH_CYCLES`, 2, number of cycles spent in FLUSH. Must be ≥1.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a live instruction.
- `id_pc`  in  XLEN  PC of the instruction in ID.
- `id_instr`  in  32  raw instruction word in ID.
- `illegal_instr`  in  1  decoder illegal-instruction flag.
- `mret_detected`  in  1  decoder MRET flag.
- `ext_irq`  in  1  level-sensitive external interrupt.
- `mtvec_we`  in  1  write strobe for `mtvec`.
- `mtvec_wdata`  in  XLEN  write data for `mtvec`.
- `mstatus_we`  in  1  write strobe for MIE/MPIE.
- `mstatus_wdata`  in  XLEN  write data; bit 3 is MIE, bit 7 is MPIE.
- `flush_if_id`  out  1  kill the IF/ID register contents.
- `flush_id_ex`  out  1  kill the ID/EX register contents.
- `stall_fetch`  out  1  hold the PC and do not fetch.
- `pc_redirect`  out  1  load `pc_target` into the PC.
- `pc_target`  out  XLEN  redirect address.
- `trap_busy`  out  1  the FSM is not in IDLE.
- `mepc`, `mcause`, `mtval`, `mtvec`  out  XLEN  CSR values.
- `mie`, `mpie`  out  1  the mstatus bits.

## Operation
- **FSM states:** IDLE, FLUSH, REDIRECT. A down-counter of width `$clog2(FLUSH_CYCLES+1)` times the FLUSH state.

- **Event acceptance (IDLE only, and only when `id_valid`=1).** Priority order:
  1. `illegal_instr`: trap.
  2. `ext_irq && mie`: interrupt.
  3. `mret_detected`: return.
- **Events outside IDLE:** ignored. Their instructions are being flushed.

- **On a trap, at the accept edge:**
  - `mepc`<=`id_pc`, `mcause`<=2, `mtval`<=`id_instr`.
  - `mpie`<=`mie`, `mie`<=0.
  - Kind latched as TRAP.
- **On an interrupt, at the accept edge:**
  - `mepc`<=`id_pc`, `mcause`<=32'h8000_000B, `mtval`<=0.
  - `mpie`<=`mie`, `mie`<=0.
  - Kind latched as TRAP.
- **On a return, at the accept edge:**
  - `mie`<=`mpie`, `mpie`<=1.
  - Kind latched as RET.
- **On any accepted event:** counter<=`FLUSH_CYCLES`, state<=FLUSH.

- **FLUSH:**
  - `flush_if_id`=`flush_id_ex`=`stall_fetch`=1.
  - The counter decrements each cycle.
  - At counter==1, go to REDIRECT.
- **REDIRECT** (exactly one cycle):
  - `pc_redirect`=1, `flush_if_id`=`flush_id_ex`=1, `stall_fetch`=0.
  - `pc_target`=`mtvec` for TRAP, `mepc` for RET.
  - Next state is IDLE.
- **Outputs in IDLE:** all control outputs are 0 and `pc_target`=0.
- **`trap_busy`:** equals (state≠IDLE).
- **Control outputs:** decoded from registered state only. There is no combinational path from the inputs to `flush_*`, `stall_fetch`, `pc_redirect` or `pc_target`.

- **CSR writes:**
  - `mtvec_we` writes `{mtvec_wdata[XLEN-1:2],2'b00}`.
  - `mstatus_we` writes `mie`/`mpie`.
  - Both are accepted in any state.
- **Write collision:** if `mstatus_we` coincides with event acceptance, the event's MIE/MPIE update wins.
- **`mtvec` write during FLUSH:** takes effect and is used by the following REDIRECT.
- **`mtvec` write during REDIRECT:** does not affect the current `pc_target`, because the registered old value is used.

## Timing
- **Reset:** while `rst_n`=0, asynchronously:
  - state=IDLE, counter=0.
  - `mtvec`=`TRAP_VECTOR`.
  - `mepc`=`mcause`=`mtval`=0, `mie`=`mpie`=0.
  - Every output is 0 except `mtvec`.
  - Reset asserted mid-FLUSH or mid-REDIRECT aborts the sequence immediately; no redirect is issued.
- **Event latency:** event sampled in ID at edge T. FLUSH is asserted in cycles T+1 … T+`FLUSH_CYCLES`. `pc_redirect` is high in cycle T+`FLUSH_CYCLES`+1. IDLE resumes at T+`FLUSH_CYCLES`+2.
- **Back-to-back events:** the earliest new acceptance is the first IDLE cycle after REDIRECT.
- **Interrupt masking:** `ext_irq` held high with `mie`=0 never traps. It traps on the first IDLE and `id_valid` cycle after `mie` becomes 1.
- **Clearing `ext_irq`:** deasserting `ext_irq` after acceptance does not cancel the sequence.

## Test plan
- **Illegal instruction:** reset, then `id_valid`=1, `id_pc`=0x40, `id_instr`=0xFFFFFFFF, `illegal_instr`=1 for one cycle.
  - Flushes are high for 2 cycles, then `pc_redirect`=1 with `pc_target`=0x100.
  - `mepc`=0x40, `mcause`=2, `mtval`=0xFFFFFFFF.
- **Interrupt masking and enable:** `ext_irq`=1 with `mie`=0.
  - No activity for 10 cycles.
  - Then `mstatus_we` with wdata=0x8: trap taken, `mcause`=0x8000000B, `mie`=0, `mpie`=1.
- **Return:** after the interrupt-scenario trap, `mret_detected`=1 with `id_valid`=1.
  - `pc_target`=`mepc` in the REDIRECT cycle.
  - Afterwards `mie`=1, `mpie`=1.
- **Priority and busy-ignore:**
  - `illegal_instr` and `ext_irq` (with `mie`=1) in the same cycle: `mcause`=2.
  - A second `illegal_instr` during FLUSH is ignored: `mepc` is unchanged and only one redirect occurs.
- **`mtvec` write timing:**
  - `mtvec_we`=1 with wdata=0x203 during FLUSH: the redirect targets 0x200.
  - The same write during REDIRECT: the current target stays at the old value.
- **Reset mid-sequence:** drop `rst_n` during FLUSH.
  - All outputs go to 0 immediately, `mtvec` returns to 0x100, and no `pc_redirect` follows release.
